// File: rtl/mm_job_if.sv
// Host-facing streams of the matrix-multiply job controller: the A/B element
// input stream and the tagged C result stream.
interface mm_job_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int N              = 4,
    parameter int OUT_DATA_WIDTH = 20
);
    // Both streams use the same valid/ready rule: a transfer happens on a rising
    // clk edge where valid and ready are both high; the sender holds its payload
    // stable while valid is high and ready is low.
    logic                      in_valid;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_DATA_WIDTH-1:0] out_data;
    logic [N-1:0]              out_row;
    logic [N-1:0]              out_col;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/mm_job_controller.sv
// Sequencer driving one MMHelper through a full job: load A, load B, then one
// compute per C element, returned row-major on a tagged valid/ready stream.
module mm_job_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int N              = 4,
    parameter int OUT_DATA_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0]              dim_m,
    input  logic [N-1:0]              dim_k,
    input  logic [N-1:0]              dim_n,
    mm_job_if.slave                   bus,
    output logic                      mm_wr_enable,
    output logic                      mm_compute_enable,
    output logic [DATA_WIDTH-1:0]     mm_in_data,
    output logic [N-1:0]              mm_i,
    output logic [N-1:0]              mm_j,
    output logic                      mm_is_first_mat,
    output logic [N-1:0]              mm_match_dim,
    input  logic [OUT_DATA_WIDTH-1:0] mm_out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        RESULT  = 3'd4,
        OUTPUT  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MAX_DIM = N[N-1:0];

    state_t                    state, next_state;
    logic [N-1:0]              m_r, k_r, n_r;
    logic [N-1:0]              row_r, col_r;
    logic [OUT_DATA_WIDTH-1:0] out_data_r;
    logic [N-1:0]              out_row_r, out_col_r;
    logic                      err_r;

    logic                      dims_ok;
    logic [N-1:0]              row_bound, col_bound;
    logic                      last_row, last_col;
    logic                      load_phase, advance;

    assign dims_ok = (dim_m != '0) && (dim_m <= MAX_DIM) &&
                     (dim_k != '0) && (dim_k <= MAX_DIM) &&
                     (dim_n != '0) && (dim_n <= MAX_DIM);

    // The counters walk A as MxK, B as KxN and C as MxN.
    always_comb begin
        row_bound = m_r;
        col_bound = n_r;
        case (state)
            LOAD_A:  begin row_bound = m_r; col_bound = k_r; end
            LOAD_B:  begin row_bound = k_r; col_bound = n_r; end
            default: begin row_bound = m_r; col_bound = n_r; end
        endcase
    end

    assign last_row   = (row_r == row_bound - ONE);
    assign last_col   = (col_r == col_bound - ONE);
    assign load_phase = (state == LOAD_A) || (state == LOAD_B);
    assign advance    = (load_phase && bus.in_valid) ||
                        ((state == OUTPUT) && bus.out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state        = state;
        bus.in_ready      = 1'b0;
        mm_is_first_mat   = 1'b0;
        mm_compute_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start && dims_ok) next_state = LOAD_A;
            end
            LOAD_A: begin
                bus.in_ready    = 1'b1;
                mm_is_first_mat = 1'b1;
                if (bus.in_valid && last_row && last_col) next_state = LOAD_B;
            end
            LOAD_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && last_row && last_col) next_state = COMPUTE;
            end
            COMPUTE: begin
                mm_compute_enable = 1'b1;
                next_state        = RESULT;
            end
            RESULT: next_state = OUTPUT;
            OUTPUT: begin
                if (bus.out_ready) next_state = (last_row && last_col) ? DONE : COMPUTE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r        <= '0;
            k_r        <= '0;
            n_r        <= '0;
            row_r      <= '0;
            col_r      <= '0;
            out_data_r <= '0;
            out_row_r  <= '0;
            out_col_r  <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r <= (state == IDLE) && start && !dims_ok;
            if ((state == IDLE) && start && dims_ok) begin
                m_r   <= dim_m;
                k_r   <= dim_k;
                n_r   <= dim_n;
                row_r <= '0;
                col_r <= '0;
            end else if (advance) begin
                // The final element of each phase wraps both counters back to 0.
                if (last_col) begin
                    col_r <= '0;
                    row_r <= last_row ? '0 : row_r + ONE;
                end else begin
                    col_r <= col_r + ONE;
                end
            end
            if (state == RESULT) begin
                out_data_r <= mm_out_data;
                out_row_r  <= row_r;
                out_col_r  <= col_r;
            end
        end
    end

    assign mm_wr_enable  = bus.in_valid & bus.in_ready;
    assign mm_in_data    = bus.in_ready ? bus.in_data : '0;
    assign mm_i          = row_r;
    assign mm_j          = col_r;
    assign mm_match_dim  = k_r;
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_data  = out_data_r;
    assign bus.out_row   = out_row_r;
    assign bus.out_col   = out_col_r;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = err_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mm_job_controller.sv
// Directed bench for mm_job_controller with a behavioural MMHelper and a
// row-major C scoreboard computed from the loaded A and B matrices.
module tb_mm_job_controller;
  localparam int DW = 8;
  localparam int NN = 4;
  localparam int OW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mm_job_if #(.DATA_WIDTH(DW), .N(NN), .OUT_DATA_WIDTH(OW)) bus ();

  logic          start;
  logic [NN-1:0] dim_m, dim_k, dim_n;
  logic          mm_wr_enable, mm_compute_enable, mm_is_first_mat;
  logic [DW-1:0] mm_in_data;
  logic [NN-1:0] mm_i, mm_j, mm_match_dim;
  logic [OW-1:0] mm_out_data;
  logic          busy, done, err;
  logic [2:0]    dbg_state;

  mm_job_controller #(.DATA_WIDTH(DW), .N(NN), .OUT_DATA_WIDTH(OW)) dut (
    .clk(clk), .reset(rst), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .bus(bus.slave),
    .mm_wr_enable(mm_wr_enable), .mm_compute_enable(mm_compute_enable),
    .mm_in_data(mm_in_data), .mm_i(mm_i), .mm_j(mm_j),
    .mm_is_first_mat(mm_is_first_mat), .mm_match_dim(mm_match_dim),
    .mm_out_data(mm_out_data),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- behavioural MMHelper ----------------
  logic signed [DW-1:0] ha [NN][NN];
  logic signed [DW-1:0] hb [NN][NN];

  function automatic logic [OW-1:0] helper_dot(input logic [NN-1:0] i, input logic [NN-1:0] j,
                                               input logic [NN-1:0] kd);
    int s;
    s = 0;
    for (int kk = 0; kk < NN; kk++)
      if (kk < int'(kd)) s += int'(ha[i][kk]) * int'(hb[kk][j]);
    return OW'(s);
  endfunction

  always @(posedge clk) begin
    if (mm_wr_enable && int'(mm_i) < NN && int'(mm_j) < NN) begin
      if (mm_is_first_mat) ha[mm_i][mm_j] <= mm_in_data;
      else                 hb[mm_i][mm_j] <= mm_in_data;
    end
    if (mm_compute_enable) mm_out_data <= helper_dot(mm_i, mm_j, mm_match_dim);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0]     exp_q[$];
  logic [2*NN-1:0]   exp_pos_q[$];
  logic [OW-1:0]     got_q[$];
  int job_a[$];
  int job_b[$];
  int wr_cnt;
  int done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic          prev_stall;
  logic [OW-1:0] prev_data;
  logic [NN-1:0] prev_row, prev_col;
  logic          ce_d1, ce_d2;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      ce_d1 = 1'b0;
      ce_d2 = 1'b0;
    end else begin
      if (mm_wr_enable && mm_compute_enable) check("wr_and_compute", 32'd1, 32'd0);
      if (mm_wr_enable) wr_cnt++;
      if (done) done_cnt++;
      if (ce_d2) check("latency_out_valid", 32'(bus.out_valid), 32'd1);
      ce_d2 = ce_d1;
      ce_d1 = mm_compute_enable;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_pos", 32'({bus.out_row, bus.out_col}), 32'({prev_row, prev_col}));
        check("stall_no_compute", 32'(mm_compute_enable), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [OW-1:0]   e;
          logic [2*NN-1:0] p;
          e = exp_q.pop_front();
          p = exp_pos_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e));
          check("out_row_col", 32'({bus.out_row, bus.out_col}), 32'(p));
        end
        got_q.push_back(bus.out_data);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_row   = bus.out_row;
      prev_col   = bus.out_col;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit gap);
    int t;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(v);
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input int m, input int k, input int n);
    dim_m = NN'(m);
    dim_k = NN'(k);
    dim_n = NN'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({busy, done, err, bus.in_ready, bus.out_valid,
                             mm_wr_enable, mm_compute_enable, mm_is_first_mat}), 32'd0);
    check({tag, "_idx"}, 32'({mm_i, mm_j, mm_match_dim, bus.out_row, bus.out_col}), 32'd0);
    check({tag, "_data"}, 32'({bus.out_data, mm_in_data}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Expected C = A x B, truncated to the result width, row-major.
  task automatic model_job(input int m, input int k, input int n);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += job_a[r*k+kk] * job_b[kk*n+c];
        exp_q.push_back(OW'(s));
        exp_pos_q.push_back({NN'(r), NN'(c)});
      end
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit gap, input bit stall);
    int t;
    got_q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    model_job(m, k, n);
    bus.out_ready = !stall;
    do_start(m, k, n);
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
    check("match_dim", 32'(mm_match_dim), 32'(k));
    foreach (job_a[i]) send(job_a[i], gap);
    foreach (job_b[i]) send(job_b[i], gap);
    if (stall) begin
      t = 0;
      while (!bus.out_valid && t < 20) begin
        tick();
        t++;
      end
      check("stall_first_valid", 32'(bus.out_valid), 32'd1);
      repeat (5) tick();
      bus.out_ready = 1'b1;
    end
    t = 0;
    while (!done && t < 300) begin
      tick();
      t++;
    end
    check("done_seen", 32'(done), 32'd1);
    tick();
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_pulse", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("results_left", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(m*k + k*n));
  endtask

  task automatic pin(input string name, input int idx, input logic [OW-1:0] v);
    if (got_q.size() > idx) check(name, 32'(got_q[idx]), 32'(v));
    else                    check({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++) begin
        ha[i][j] = '0;
        hb[i][j] = '0;
      end
    mm_out_data   = '0;
    start         = 1'b0;
    dim_m         = '0;
    dim_k         = '0;
    dim_n         = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    wr_cnt        = 0;
    done_cnt      = 0;

    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 2x2x2 basic job
    job_a = '{1, 2, 3, 4};
    job_b = '{5, 6, 7, 8};
    run_job(2, 2, 2, 1'b0, 1'b0);
    pin("c2x2_00", 0, 20'd19);
    pin("c2x2_01", 1, 20'd22);
    pin("c2x2_10", 2, 20'd43);
    pin("c2x2_11", 3, 20'd50);

    // 1x1 signed product
    job_a = '{-3};
    job_b = '{5};
    run_job(1, 1, 1, 1'b0, 1'b0);
    pin("c1x1_neg", 0, 20'hFFFF1);

    // 4x4 extreme values
    job_a.delete();
    job_b.delete();
    for (int i = 0; i < 16; i++) begin
      job_a.push_back(-128);
      job_b.push_back(-128);
    end
    run_job(4, 4, 4, 1'b0, 1'b0);
    pin("c4x4_first", 0, 20'd65536);
    pin("c4x4_last", 15, 20'd65536);

    // Non-square with in_valid gaps
    job_a = '{1, 2, 3, 4, 5, 6};
    job_b = '{1, 1, 1};
    run_job(2, 3, 1, 1'b1, 1'b0);
    pin("c231_0", 0, 20'd6);
    pin("c231_1", 1, 20'd15);

    // Back-pressure on the first result
    job_a = '{1, 2, 3, 4};
    job_b = '{5, 6, 7, 8};
    run_job(2, 2, 2, 1'b0, 1'b1);
    pin("stall_c00", 0, 20'd19);
    pin("stall_c11", 3, 20'd50);

    // Rejected starts
    do_start(2, 0, 2);
    check("err_k0", 32'(err), 32'd1);
    check("err_k0_busy", 32'({busy, bus.in_ready}), 32'd0);
    tick();
    check("err_k0_pulse", 32'({err, busy, bus.in_ready}), 32'd0);
    do_start(2, 2, 5);
    check("err_n5", 32'(err), 32'd1);
    check("err_n5_busy", 32'({busy, bus.in_ready}), 32'd0);
    tick();
    check("err_n5_pulse", 32'({err, busy, bus.in_ready}), 32'd0);

    // Reset in the middle of LOAD_B
    job_a = '{9, 9, 9, 9};
    job_b = '{9, 9, 9, 9};
    do_start(2, 2, 2);
    for (int i = 0; i < 4; i++) send(job_a[i], 1'b0);
    send(job_b[0], 1'b0);
    send(job_b[1], 1'b0);
    check("pre_reset_load_b", 32'({bus.in_ready, mm_is_first_mat}), 32'b10);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("postreset");
    job_a = '{1, 2, 3, 4};
    job_b = '{5, 6, 7, 8};
    run_job(2, 2, 2, 1'b0, 1'b0);
    pin("fresh_c00", 0, 20'd19);
    pin("fresh_c01", 1, 20'd22);
    pin("fresh_c10", 2, 20'd43);
    pin("fresh_c11", 3, 20'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
